// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the instruction prefetch controller.
package prefetch_pkg;

    typedef enum logic [0:0] {IDLE, REQ} fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;

    // True when one more request can be issued without overflowing the FIFO.
    function automatic logic credit_ok(input int unsigned occ, input int unsigned outstanding,
                                       input int unsigned discard, input int unsigned max_out,
                                       input int unsigned depth);
        return (outstanding < max_out) && ((occ + outstanding - discard) < depth);
    endfunction

endpackage

// File: rtl/instr_prefetch_ctrl.sv
// Instruction fetch controller: issues OBI word fetches, pushes responses into the
// downstream FIFO under a credit limit, and redirects/discards on branches.
module instr_prefetch_ctrl
    import prefetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        fifo_push_o,
    output logic [31:0] fifo_data_o,
    output logic        fifo_flush_o,
    input  logic        fifo_pop_i
);

    localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     fetch_addr_q, fetch_addr_d;
    logic            redirect_q, redirect_d;
    logic [OutW-1:0] outstanding_q, outstanding_d;
    logic [OutW-1:0] discard_q, discard_d;
    logic [OccW-1:0] occ_q, occ_d;
    logic            gnt_fire, push, pop, may_issue_now, may_issue_next;
    logic [31:0]     branch_target;

    assign branch_target = branch_addr_i & ~32'h3;
    assign gnt_fire      = (state_q == REQ) && instr_gnt_i;
    assign push          = instr_rvalid_i && (discard_q == '0) && !branch_i;
    assign pop           = fifo_pop_i && (occ_q != '0);
    assign may_issue_now = fetch_en_i && credit_ok(32'(occ_q), 32'(outstanding_q),
                                                   32'(discard_q), MAX_OUTSTANDING, FIFO_DEPTH);

    assign instr_req_o  = (state_q == REQ);
    assign instr_addr_o = addr_q;
    assign fifo_push_o  = push;
    assign fifo_data_o  = instr_rdata_i;
    assign fifo_flush_o = branch_i;

    always_comb begin
        outstanding_d = outstanding_q;
        if (gnt_fire && !instr_rvalid_i) begin
            outstanding_d = outstanding_q + OutW'(1);
        end else if (!gnt_fire && instr_rvalid_i) begin
            outstanding_d = outstanding_q - OutW'(1);
        end

        // A request granted after a branch overtook it belongs to the old stream.
        discard_d = discard_q;
        if (branch_i) begin
            discard_d = outstanding_d;
        end else begin
            if (instr_rvalid_i && (discard_q != '0)) discard_d = discard_d - OutW'(1);
            if (gnt_fire && redirect_q) discard_d = discard_d + OutW'(1);
        end

        occ_d = occ_q;
        if (branch_i) begin
            occ_d = '0;
        end else if (push && !pop) begin
            occ_d = occ_q + OccW'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OccW'(1);
        end

        fetch_addr_d = fetch_addr_q;
        redirect_d   = redirect_q;
        if (gnt_fire) begin
            redirect_d = 1'b0;
            if (!redirect_q) fetch_addr_d = fetch_addr_q + 32'(INSTR_BYTES);
        end
        if (branch_i) begin
            fetch_addr_d = branch_target;
            redirect_d   = (state_q == REQ) && !instr_gnt_i;
        end

        may_issue_next = fetch_en_i && credit_ok(32'(occ_d), 32'(outstanding_d),
                                                 32'(discard_d), MAX_OUTSTANDING, FIFO_DEPTH);

        state_d = state_q;
        unique case (state_q)
            IDLE: if (may_issue_now && !branch_i) state_d = REQ;
            REQ:  if (gnt_fire && !may_issue_next) state_d = IDLE;
        endcase

        // Bus address is frozen while a request waits for its grant.
        addr_d = ((state_q == REQ) && !instr_gnt_i) ? addr_q : fetch_addr_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            addr_q        <= BOOT_ADDR;
            fetch_addr_q  <= BOOT_ADDR;
            redirect_q    <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            occ_q         <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            fetch_addr_q  <= fetch_addr_d;
            redirect_q    <= redirect_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            occ_q         <= occ_d;
        end
    end

`ifndef SYNTHESIS
    a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_rvalid_i |-> (outstanding_q != '0));
    a_push_room: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_push_o |-> (32'(occ_q) < FIFO_DEPTH));
    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (instr_req_o && !instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)));
    a_out_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (32'(outstanding_q) <= MAX_OUTSTANDING) && (discard_q <= outstanding_q));
    a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        32'(occ_q) <= FIFO_DEPTH);
`endif

endmodule

// File: tb/tb_instr_prefetch_ctrl.sv
// Directed bench for instr_prefetch_ctrl with a bus responder and a push scoreboard.
module tb_instr_prefetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        fetch_en_i, branch_i, instr_gnt_i, instr_rvalid_i, fifo_pop_i;
    logic [31:0] branch_addr_i, instr_rdata_i;
    logic        instr_req_o, fifo_push_o, fifo_flush_o;
    logic [31:0] instr_addr_o, fifo_data_o;

    logic        w_en, w_req, w_push, w_flush;
    logic [31:0] w_addr, w_data;

    int          checks = 0;
    int          errors = 0;
    int          grants = 0;
    int          pushes = 0;
    int          w_grants = 0;
    int          epoch = 0;
    int          mdl_occ = 0;
    int          g0, p0;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] w_exp = 32'hFFFF_FFFC;
    logic [31:0] pend_target = 32'h0;
    bit          pend_valid = 1'b0;
    bit          hold = 1'b0;
    bit          done;
    logic [31:0] sb_data[$];
    int          sb_epoch[$];

    always #5 clk_i = ~clk_i;

    instr_prefetch_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .fetch_en_i(fetch_en_i), .branch_i(branch_i),
        .branch_addr_i(branch_addr_i), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i), .fifo_push_o(fifo_push_o), .fifo_data_o(fifo_data_o),
        .fifo_flush_o(fifo_flush_o), .fifo_pop_i(fifo_pop_i)
    );

    instr_prefetch_ctrl #(.BOOT_ADDR(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk_i), .rst_ni(rst_ni), .fetch_en_i(w_en), .branch_i(1'b0),
        .branch_addr_i(32'h0), .instr_req_o(w_req), .instr_addr_o(w_addr),
        .instr_gnt_i(1'b1), .instr_rvalid_i(1'b0), .instr_rdata_i(32'h0),
        .fifo_push_o(w_push), .fifo_data_o(w_data), .fifo_flush_o(w_flush), .fifo_pop_i(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample and score at the negedge, then drive the responder after the posedge.
    task automatic cycle();
        logic [31:0] d;
        int          e, nxt;
        bit          keep;
        @(negedge clk_i);
        keep = 1'b0;
        check("occ", 32'(dut.occ_q), 32'(mdl_occ));
        check("flush", 32'(fifo_flush_o), 32'(branch_i));
        if (instr_req_o && instr_gnt_i) begin
            check("req_addr", instr_addr_o, exp_addr);
            grants++;
            sb_data.push_back(~instr_addr_o);
            sb_epoch.push_back(pend_valid ? -1 : epoch);
            exp_addr   = pend_valid ? pend_target : exp_addr + 32'd4;
            pend_valid = 1'b0;
        end
        if (instr_rvalid_i) begin
            d    = sb_data.pop_front();
            e    = sb_epoch.pop_front();
            keep = (e == epoch) && !branch_i;
            check("push_on_rvalid", 32'(fifo_push_o), 32'(keep));
            if (keep && fifo_push_o) check("push_data", fifo_data_o, d);
        end else begin
            check("push_idle", 32'(fifo_push_o), 32'd0);
        end
        if (fifo_push_o) pushes++;
        nxt = mdl_occ;
        if (keep) nxt++;
        if (fifo_pop_i && mdl_occ > 0) nxt--;
        mdl_occ = branch_i ? 0 : nxt;
        if (branch_i) begin
            epoch++;
            if (instr_req_o && !instr_gnt_i) begin
                pend_valid  = 1'b1;
                pend_target = branch_addr_i & ~32'h3;
            end else begin
                exp_addr = branch_addr_i & ~32'h3;
            end
        end
        if (w_req) begin
            check("wrap_addr", w_addr, w_exp);
            w_exp += 32'd4;
            w_grants++;
        end
        @(posedge clk_i);
        #1;
        branch_i       = 1'b0;
        instr_rvalid_i = (sb_data.size() > 0) && !hold;
        instr_rdata_i  = (sb_data.size() > 0) ? sb_data[0] : 32'h0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!instr_req_o && n < 20) begin
            cycle();
            n++;
        end
        check(tag, 32'(instr_req_o), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_ni = 1'b0; fetch_en_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0;
        instr_gnt_i = 1'b1; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0; fifo_pop_i = 1'b0;
        w_en = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_req", 32'(instr_req_o), 32'd0);
        check("rst_addr", instr_addr_o, 32'h0);
        check("rst_push", 32'(fifo_push_o), 32'd0);
        check("rst_flush", 32'(fifo_flush_o), 32'd0);
        check("rst_outstanding", 32'(dut.outstanding_q), 32'd0);
        check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
        rst_ni = 1'b1;
        fetch_en_i = 1'b1;
        w_en = 1'b1;

        // Boot stream until credit runs out.
        repeat (8) cycle();
        check("boot_grants", 32'(grants), 32'd2);
        check("boot_pushes", 32'(pushes), 32'd2);
        check("wrap_grants", 32'(w_grants), 32'd2);
        repeat (3) begin
            cycle();
            check("full_no_req", 32'(instr_req_o), 32'd0);
        end

        // One pop frees exactly one slot.
        hold = 1'b1;
        fifo_pop_i = 1'b1;
        cycle();
        fifo_pop_i = 1'b0;
        repeat (6) cycle();
        check("bp_one_req", 32'(grants), 32'd3);
        hold = 1'b0;
        repeat (3) cycle();
        check("bp_occ", 32'(dut.occ_q), 32'd2);
        check("bp_pushes", 32'(pushes), 32'd3);

        // Branch with two responses in flight.
        hold = 1'b1;
        fifo_pop_i = 1'b1;
        repeat (2) cycle();
        fifo_pop_i = 1'b0;
        repeat (5) cycle();
        check("pre_br_grants", 32'(grants), 32'd5);
        check("pre_br_out", 32'(dut.outstanding_q), 32'd2);
        branch_i = 1'b1;
        branch_addr_i = 32'h103;
        cycle();
        check("br_discard", 32'(dut.discard_q), 32'd2);
        check("br_occ", 32'(dut.occ_q), 32'd0);
        hold = 1'b0;
        repeat (8) cycle();
        check("br_pushes", 32'(pushes), 32'd5);
        check("br_grants", 32'(grants), 32'd7);

        // Branch while a request waits for its grant.
        instr_gnt_i = 1'b0;
        fifo_pop_i = 1'b1;
        repeat (2) cycle();
        fifo_pop_i = 1'b0;
        wait_req("pend_req");
        check("pend_addr", instr_addr_o, 32'h108);
        branch_i = 1'b1;
        branch_addr_i = 32'h200;
        cycle();
        repeat (2) cycle();
        check("held_addr", instr_addr_o, 32'h108);
        instr_gnt_i = 1'b1;
        repeat (8) cycle();
        check("pend_pushes", 32'(pushes), 32'd7);

        // Streaming with concurrent push/pop, then a branch on an rvalid cycle.
        fifo_pop_i = 1'b1;
        repeat (6) cycle();
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            if (instr_rvalid_i) begin
                branch_i = 1'b1;
                branch_addr_i = 32'h300;
                cycle();
                check("br_rv_occ", 32'(dut.occ_q), 32'd0);
                done = 1'b1;
            end else begin
                cycle();
            end
        end
        check("br_rv_seen", 32'(done), 32'd1);
        fifo_pop_i = 1'b0;
        repeat (10) cycle();

        // Disable while a request is pending: it completes, nothing further issues.
        instr_gnt_i = 1'b0;
        fifo_pop_i = 1'b1;
        repeat (3) cycle();
        fifo_pop_i = 1'b0;
        wait_req("dis_req");
        fetch_en_i = 1'b0;
        cycle();
        g0 = grants;
        p0 = pushes;
        instr_gnt_i = 1'b1;
        repeat (4) cycle();
        check("dis_grants", 32'(grants), 32'(g0 + 1));
        check("dis_pushes", 32'(pushes), 32'(p0 + 1));
        repeat (4) begin
            cycle();
            check("dis_no_req", 32'(instr_req_o), 32'd0);
        end

        // Asynchronous reset in the middle of traffic.
        fetch_en_i = 1'b1;
        fifo_pop_i = 1'b1;
        repeat (3) cycle();
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_out", 32'(dut.outstanding_q), 32'd0);
        check("mid_rst_occ", 32'(dut.occ_q), 32'd0);
        check("mid_rst_disc", 32'(dut.discard_q), 32'd0);
        check("mid_rst_req", 32'(instr_req_o), 32'd0);
        check("mid_rst_addr", instr_addr_o, 32'h0);
        instr_rvalid_i = 1'b0;
        fifo_pop_i = 1'b0;
        sb_data.delete();
        sb_epoch.delete();
        mdl_occ = 0;
        exp_addr = 32'h0;
        pend_valid = 1'b0;
        w_en = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        g0 = grants;
        repeat (6) cycle();
        check("post_rst_grants", 32'(grants), 32'(g0 + 2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
